// File: rtl/bullet_scheduler.sv
// bullet_scheduler
//   Per-tank fire controller, clocked once per video frame. Decodes the fire
//   key from four USB keycode bytes and enforces a magazine, a cooldown
//   between accepted shots and a timed reload. Bullet slots are handed out
//   round-robin, skipping slots that are still in flight.
//
//   Optional feature macro: AUTOFIRE_EN
//     defined   - in IDLE a held key keeps firing (level trigger)
//     undefined - every shot needs a release and a fresh press (edge trigger)
//
// Ports
//   frame_clk        frame tick, only clock
//   reset_n          asynchronous active-low reset
//   clear            synchronous round restart
//   enable           game is in its playing state
//   keycode0..3      current USB keycodes
//   slot_busy[2:0]   bullet slot i is in flight
//   launch[2:0]      one-hot, one-frame spawn pulse for slot i
//   ammo[3:0]        shots left in the magazine
//   reloading        reload in progress
//   fire_denied      one-frame pulse for a rejected fire request
module bullet_scheduler #(
    parameter logic [7:0]  FIRE_KEY = 8'd44,
    parameter int unsigned COOLDOWN = 8,
    parameter int unsigned MAG_SIZE = 6,
    parameter int unsigned RELOAD   = 60
) (
    input  logic       frame_clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    input  logic [2:0] slot_busy,
    output logic [2:0] launch,
    output logic [3:0] ammo,
    output logic       reloading,
    output logic       fire_denied
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_RELOAD   = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] ammo_n;
    logic [1:0] ptr, ptr_n;
    logic       fire_req_d, fire_req_d_n;
    logic [2:0] launch_n;
    logic       fire_denied_n;

    logic       fire_req;
    logic       press;
    logic       trigger;
    logic       found;
    logic [1:0] slot;
    logic [1:0] cand;

    function automatic logic [1:0] next_slot(input logic [1:0] s);
        return (s >= 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    always_ff @(posedge frame_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ammo        <= 4'(MAG_SIZE);
            ptr         <= '0;
            fire_req_d  <= 1'b0;
            launch      <= '0;
            fire_denied <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ammo        <= ammo_n;
            ptr         <= ptr_n;
            fire_req_d  <= fire_req_d_n;
            launch      <= launch_n;
            fire_denied <= fire_denied_n;
        end
    end

    assign reloading = (state == ST_RELOAD);

    always_comb begin
        fire_req = enable && ((keycode0 == FIRE_KEY) || (keycode1 == FIRE_KEY) ||
                              (keycode2 == FIRE_KEY) || (keycode3 == FIRE_KEY));
        press    = fire_req && !fire_req_d;
`ifdef AUTOFIRE_EN
        trigger  = fire_req;
`else
        trigger  = press;
`endif

        // First free slot searching ptr, ptr+1, ptr+2 (mod 3).
        found = 1'b0;
        slot  = '0;
        cand  = ptr;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!found && !slot_busy[cand]) begin
                found = 1'b1;
                slot  = cand;
            end
            cand = next_slot(cand);
        end

        state_n       = state;
        cnt_n         = cnt;
        ammo_n        = ammo;
        ptr_n         = ptr;
        launch_n      = '0;
        fire_denied_n = 1'b0;
        fire_req_d_n  = fire_req;

        if (clear) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            ammo_n  = 4'(MAG_SIZE);
            ptr_n   = '0;
        end else if (enable) begin
            unique case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        if ((ammo != 4'd0) && found) begin
                            launch_n[slot] = 1'b1;
                            ammo_n         = ammo - 4'd1;
                            ptr_n          = next_slot(slot);
                            if (ammo == 4'd1) begin
                                cnt_n   = 8'(RELOAD - 1);
                                state_n = ST_RELOAD;
                            end else begin
                                cnt_n   = 8'(COOLDOWN - 1);
                                state_n = ST_COOLDOWN;
                            end
                        end else begin
                            fire_denied_n = 1'b1;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    // Held key under autofire is denied only on its leading edge.
                    fire_denied_n = press;
                    if (cnt == 8'd0) state_n = ST_IDLE;
                    else             cnt_n   = cnt - 8'd1;
                end
                ST_RELOAD: begin
                    fire_denied_n = press;
                    if (cnt == 8'd0) begin
                        ammo_n  = 4'(MAG_SIZE);
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_scheduler.sv
// tb_bullet_scheduler
//   Directed scoreboard bench for bullet_scheduler (default build, no
//   AUTOFIRE_EN). Stimulus pushes the expected {launch, fire_denied, ammo,
//   reloading} for every frame that should pulse; a negedge monitor pops and
//   compares whenever launch or fire_denied is high.
module tb_bullet_scheduler;

    logic       frame_clk;
    logic       reset_n;
    logic       clear;
    logic       enable;
    logic [7:0] keycode0, keycode1, keycode2, keycode3;
    logic [2:0] slot_busy;
    logic [2:0] launch;
    logic [3:0] ammo;
    logic       reloading;
    logic       fire_denied;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [8:0]  exp_q[$];

    bullet_scheduler #(
        .FIRE_KEY (8'd44),
        .COOLDOWN (8),
        .MAG_SIZE (6),
        .RELOAD   (60)
    ) dut (
        .frame_clk   (frame_clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .enable      (enable),
        .keycode0    (keycode0),
        .keycode1    (keycode1),
        .keycode2    (keycode2),
        .keycode3    (keycode3),
        .slot_busy   (slot_busy),
        .launch      (launch),
        .ammo        (ammo),
        .reloading   (reloading),
        .fire_denied (fire_denied)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    // Monitor: outputs change on posedge, sampled on negedge.
    always @(negedge frame_clk) begin
        logic [8:0] act;
        logic [8:0] exp;
        act = {launch, fire_denied, ammo, reloading};
        if (reset_n && (launch != 3'b000 || fire_denied)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got %b expected no pulse", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL pulse: got {launch,denied,ammo,rel}=%b expected %b", act, exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #2;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    // Key high for exactly one sampled frame, then one released frame.
    task automatic press_at();
        keycode2 = 8'd44;
        tick();
        keycode2 = 8'd0;
        tick();
    endtask

    task automatic expect_pulse(input logic [2:0] l, input logic d,
                                input logic [3:0] a, input logic r);
        exp_q.push_back({l, d, a, r});
    endtask

    task automatic empty_magazine();
        for (int unsigned i = 0; i < 6; i++) begin
            expect_pulse(3'b001 << (i % 3), 1'b0, 4'(5 - i), (i == 5));
            press_at();
            if (i < 5) idle(8);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b1;
        clear     = 1'b0;
        enable    = 1'b1;
        keycode0  = 8'd0;
        keycode1  = 8'd4;
        keycode2  = 8'd0;
        keycode3  = 8'd0;
        slot_busy = 3'b000;

        #1 reset_n = 1'b0;
        #1;
        check("reset_launch", 32'(launch), 32'd0);
        check("reset_ammo", 32'(ammo), 32'd6);
        check("reset_reloading", 32'(reloading), 32'd0);
        check("reset_denied", 32'(fire_denied), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single shot, denial during cooldown, cooldown boundaries.
        expect_pulse(3'b001, 1'b0, 4'd5, 1'b0);
        press_at();                              // P, P+1
        idle(1);
        expect_pulse(3'b000, 1'b1, 4'd5, 1'b0);
        press_at();                              // P+3
        idle(4);
        expect_pulse(3'b010, 1'b0, 4'd4, 1'b0);
        press_at();                              // P+9: earliest next shot
        idle(6);
        expect_pulse(3'b000, 1'b1, 4'd4, 1'b0);
        press_at();                              // Q+8: still cooling down
        expect_pulse(3'b100, 1'b0, 4'd3, 1'b0);
        press_at();                              // Q+10

        // Clear from COOLDOWN restores magazine and pointer.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_ammo", 32'(ammo), 32'd6);
        check("clear_reloading", 32'(reloading), 32'd0);

        // Six shots, denial mid-reload, reload completion timing.
        empty_magazine();                        // last shot at S
        idle(8);
        expect_pulse(3'b000, 1'b1, 4'd0, 1'b1);
        press_at();                              // S+10
        idle(48);                                // through S+59
        check("reload_ammo_before", 32'(ammo), 32'd0);
        check("reload_flag_before", 32'(reloading), 32'd1);
        tick();                                  // S+60
        check("reload_ammo_after", 32'(ammo), 32'd6);
        check("reload_flag_after", 32'(reloading), 32'd0);
        expect_pulse(3'b001, 1'b0, 4'd5, 1'b0);
        press_at();                              // S+61

        // Busy-slot skipping and all-busy denial.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        slot_busy = 3'b011;
        expect_pulse(3'b100, 1'b0, 4'd5, 1'b0);
        press_at();
        idle(7);
        slot_busy = 3'b111;
        expect_pulse(3'b000, 1'b1, 4'd5, 1'b0);
        press_at();
        slot_busy = 3'b000;
        expect_pulse(3'b001, 1'b0, 4'd4, 1'b0);  // ptr wrapped to 0
        press_at();

        // Key pressed in the clear frame and held: nothing fires.
        keycode0 = 8'd44;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle(20);
        keycode0 = 8'd0;
        tick();
        check("held_through_clear_ammo", 32'(ammo), 32'd6);

        // Asynchronous reset in the middle of a reload (cnt = 30).
        empty_magazine();                        // last shot at S2
        idle(28);                                // through S2+29
        check("pre_reset_reloading", 32'(reloading), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midreload_reset_ammo", 32'(ammo), 32'd6);
        check("midreload_reset_reloading", 32'(reloading), 32'd0);
        check("midreload_reset_launch", 32'(launch), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // enable low freezes COOLDOWN at cnt = 4; presses ignored meanwhile.
        expect_pulse(3'b001, 1'b0, 4'd5, 1'b0);
        press_at();                              // V, V+1
        idle(2);                                 // V+3 leaves cnt = 4
        enable = 1'b0;
        press_at();
        idle(8);
        check("disabled_ammo", 32'(ammo), 32'd5);
        enable = 1'b1;
        idle(3);                                 // E1..E3
        expect_pulse(3'b000, 1'b1, 4'd5, 1'b0);
        press_at();                              // E4: cnt was 1
        expect_pulse(3'b010, 1'b0, 4'd4, 1'b0);
        press_at();                              // E6: IDLE since E5
        idle(2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bullet_scheduler.md
# bullet_scheduler

Per-tank fire controller that decides when, and into which of the tank's three bullet slots, a new bullet is launched. It decodes the fire key from the four USB keycode bytes and enforces a magazine, a cooldown between shots, and a timed reload. Slots are handed out round-robin. It sits between the keycode registers and the tank's bullet datapath, and is clocked once per frame. Two instances are used, one per tank, each with its own FIRE_KEY.

## Interface
Parameters:
- FIRE_KEY, 8'd44: USB keycode that requests a shot.
- COOLDOWN, 8: frames between accepted shots; legal range 1–255.
- MAG_SIZE, 6: shots per magazine; legal range 1–15.
- RELOAD, 60: frames spent reloading once the magazine is empty; legal range 1–255.

Ports:
- frame_clk, in, 1: the only clock; the vertical-sync frame tick.
- reset_n, in, 1: asynchronous, active-low reset.
- clear, in, 1: synchronous round restart, driven from game_reset.
- enable, in, 1: high while the game is in its playing state.
- keycode0..keycode3, in, 8 each: current USB keycodes.
- slot_busy, in, 3: bullet slot i is in flight.
- launch, out, 3: one-hot, one-frame pulse that spawns a bullet in slot i.
- ammo, out, 4: shots left in the magazine.
- reloading, out, 1: high while the RELOAD state is active.
- fire_denied, out, 1: one-frame pulse when a fire request is rejected.

## Operation
- fire_req = enable AND (any keycodeN == FIRE_KEY). fire_req_d is the registered copy. press = fire_req AND NOT fire_req_d.
- States are IDLE, COOLDOWN and RELOAD. Registers are the state, cnt[7:0], ammo, ptr[1:0] (0..2), fire_req_d, launch and fire_denied.
- IDLE with a trigger (press, or see Configuration):
  - Fire only if ammo > 0 and at least one slot_busy bit is 0.
  - The chosen slot is the first free slot searching ptr, ptr+1, ptr+2, all mod 3.
  - launch[slot] is set, ammo is decremented, and ptr becomes (slot+1) mod 3.
  - If the new ammo is 0, load cnt = RELOAD-1 and go to RELOAD.
  - Otherwise load cnt = COOLDOWN-1 and go to COOLDOWN.
- IDLE, trigger with ammo == 0 or all slots busy: pulse fire_denied; state is unchanged. ammo == 0 in IDLE is unreachable except through misuse and is handled the same way.
- COOLDOWN: when cnt == 0 go to IDLE, otherwise decrement cnt. A trigger here pulses fire_denied and is not queued.
- RELOAD: when cnt == 0 set ammo = MAG_SIZE and go to IDLE, otherwise decrement cnt. A trigger pulses fire_denied. reloading = (state == RELOAD).
- enable low: state, cnt, ammo and ptr freeze. launch and fire_denied are 0. fire_req_d still updates, and fire_req is 0 while enable is low.
- clear (priority over everything except reset_n):
  - state = IDLE, cnt = 0, ammo = MAG_SIZE, ptr = 0, launch = 0, fire_denied = 0.
  - fire_req_d = fire_req, so a key already held at clear does not fire.
- Arithmetic: cnt and ammo never wrap. Decrements are guarded by the zero checks above.

## Timing
- Reset values (reset_n low, asynchronous): state = IDLE, cnt = 0, ammo = MAG_SIZE, ptr = 0, fire_req_d = 0, launch = 3'b000, reloading = 0, fire_denied = 0.
- Every output is registered. A keycode and slot_busy sampled at edge k produce launch or fire_denied high from edge k until edge k+1, for exactly one frame.
- Shot spacing: the second accepted press is launched at the earliest COOLDOWN+1 frames after the first.
- After the shot that empties the magazine, ammo returns to MAG_SIZE RELOAD frames later. The next shot can launch on the frame after that.
- slot_busy is trusted at the sampling edge. The datapath raises busy within COOLDOWN frames of launch, and COOLDOWN ≥ 1 guarantees no slot is double-issued.
- A clear and a press in the same frame: clear wins and nothing launches.
- reset_n deasserted mid-reload: the block returns to IDLE with a full magazine.

## Configuration
- AUTOFIRE_EN defined: in IDLE the trigger is fire_req, which is level-sensitive. Holding the key fires every COOLDOWN+1 frames until the magazine empties, then resumes after the reload. With the key held in COOLDOWN or RELOAD, fire_denied pulses only on press, not every frame.
- AUTOFIRE_EN undefined: the trigger is press only, so each shot needs a release and a fresh press.

## Test plan
- Reset, enable=1, all slots free, press FIRE_KEY on keycode2 for one frame → launch = 001 one frame later, ammo = 5, COOLDOWN entered; press again 3 frames later → fire_denied pulse, no launch.
- Release-and-press six times spaced 10 frames apart → launch sequence 001, 010, 100, 001, 010, 100; after the 6th shot ammo = 0 and reloading = 1; 60 frames later ammo = 6 and reloading = 0.
- slot_busy = 011 with ptr = 0 and a press → launch = 100, ptr = 0; slot_busy = 111 and a press → fire_denied, ammo unchanged.
- Key held through clear, then kept held → no launch without AUTOFIRE_EN; with AUTOFIRE_EN, launch on the frame after clear, then every 9 frames.
- Assert reset_n low for one frame during RELOAD with cnt = 30 → immediately ammo = 6, reloading = 0, launch = 000.
- enable = 0 during COOLDOWN with cnt = 4 for 10 frames, then enable = 1 → cnt resumes at 4; a press while disabled has no effect.
